// File: rtl/matmul_mac_sequencer.sv
// matmul_mac_sequencer: issues A/B reads for C = A x B, accumulates in a MAC and writes C.
// Define MATMUL_SEQ_CYCLE_CNT_EN to add the cycle_cnt busy-cycle counter output.
module matmul_mac_sequencer #(
  parameter int LOG2N  = 6,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic [2*LOG2N-1:0]   a_addr,
  output logic [2*LOG2N-1:0]   b_addr,
  output logic                 ab_re,
  input  logic [DATA_W-1:0]    a_dout,
  input  logic [DATA_W-1:0]    b_dout,
  output logic                 c_we,
  output logic [2*LOG2N-1:0]   c_addr,
  output logic [ACC_W-1:0]     c_din,
  output logic                 busy,
  output logic                 done
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);
  localparam int AW     = 2*LOG2N;
  localparam int PW     = AW + 3;
  localparam int PIPE_W = RD_LAT*PW;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t             r_state, w_nxt;
  logic [3*LOG2N-1:0] r_cnt;
  logic [LOG2N-1:0]   w_i, w_j, w_k;
  logic [PIPE_W-1:0]  r_pipe;
  logic [PW-1:0]      w_out;
  logic [ACC_W-1:0]   r_acc, w_sum, r_c_din;
  logic [AW-1:0]      r_c_addr;
  logic               r_c_we, w_start, w_last_issue, w_last_wr;
  assign {w_i, w_j, w_k} = r_cnt;
  assign w_start      = r_state == S_IDLE && start;
  assign w_last_issue = &r_cnt;
  // Earlier elements may still write during DRAIN, so match the final address too.
  assign w_last_wr    = r_c_we && &r_c_addr;
  // Oldest pipeline stage: {valid, first_k, last_k, i, j}, aligned with the read data.
  assign w_out        = r_pipe[PIPE_W-1 -: PW];
  assign w_sum        = (w_out[PW-2] ? '0 : r_acc) + ACC_W'(a_dout) * ACC_W'(b_dout);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_nxt;
  always_comb
    w_nxt = w_start ? S_ISSUE
          : (r_state == S_ISSUE && w_last_issue) ? S_DRAIN
          : (r_state == S_DRAIN && w_last_wr) ? S_DONE
          : (r_state == S_DONE) ? S_IDLE : r_state;
  always_comb begin
    ab_re  = r_state == S_ISSUE;
    busy   = r_state == S_ISSUE || r_state == S_DRAIN;
    done   = r_state == S_DONE;
    a_addr = {w_i, w_k};
    b_addr = {w_k, w_j};
    c_we   = r_c_we;
    c_addr = r_c_addr;
    c_din  = r_c_din;
  end
  // Counter stops on the final issue so addresses hold through DRAIN.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else if (w_start) r_cnt <= '0;
    else if (ab_re && !w_last_issue) r_cnt <= r_cnt + 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_pipe   <= '0;
      r_acc    <= '0;
      r_c_we   <= 1'b0;
      r_c_addr <= '0;
      r_c_din  <= '0;
    end else begin
      r_pipe <= PIPE_W'({r_pipe, ab_re, w_k == '0, &w_k, w_i, w_j});
      if (w_out[PW-1]) r_acc <= w_sum;
      r_c_we <= w_out[PW-1] && w_out[PW-3];
      if (w_out[PW-1] && w_out[PW-3]) begin
        r_c_addr <= w_out[AW-1:0];
        r_c_din  <= w_sum;
      end
    end
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  logic [31:0] r_cyc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cyc <= '0;
    else if (w_start) r_cyc <= '0;
    else if (busy) r_cyc <= r_cyc + 32'd1;
  assign cycle_cnt = r_cyc;
`endif
endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// tb_matmul_mac_sequencer: scoreboard bench for a 4x4 run with 3-cycle SRAM latency.
module tb_matmul_mac_sequencer;
  localparam int LOG2N = 2, N = 1 << LOG2N, NN = N*N, N3 = NN*N;
  localparam int DATA_W = 8, ACC_W = 22, RD_LAT = 3, AW = 2*LOG2N;
  localparam int T_DONE = N3 + RD_LAT + 2;
  logic clk = 0, rstn = 0, start = 0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic ab_re, c_we, busy, done;
  logic [DATA_W-1:0] a_dout, b_dout;
  logic [ACC_W-1:0] c_din;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif
  logic [DATA_W-1:0] mem_a [NN], mem_b [NN], pa [RD_LAT], pb [RD_LAT];
  logic [AW-1:0] q_addr [$];
  logic [ACC_W-1:0] q_data [$];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  matmul_mac_sequencer #(.LOG2N(LOG2N), .DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .a_addr(a_addr), .b_addr(b_addr), .ab_re(ab_re),
    .a_dout(a_dout), .b_dout(b_dout),
    .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
    .busy(busy), .done(done)
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  // SRAM model: data appears RD_LAT cycles after the read-enable cycle.
  assign a_dout = pa[RD_LAT-1];
  assign b_dout = pb[RD_LAT-1];
  always @(posedge clk) begin
    pa[0] <= ab_re ? mem_a[a_addr] : 8'h5a;
    pb[0] <= ab_re ? mem_b[b_addr] : 8'ha5;
    for (int s = 1; s < RD_LAT; s++) begin
      pa[s] <= pa[s-1];
      pb[s] <= pb[s-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "/a_addr"}, 64'(a_addr), 0);
    chk({nm, "/b_addr"}, 64'(b_addr), 0);
    chk({nm, "/ab_re"}, 64'(ab_re), 0);
    chk({nm, "/c_we"}, 64'(c_we), 0);
    chk({nm, "/c_addr"}, 64'(c_addr), 0);
    chk({nm, "/c_din"}, 64'(c_din), 0);
    chk({nm, "/busy"}, 64'(busy), 0);
    chk({nm, "/done"}, 64'(done), 0);
  endtask

  // mode 0: identity x ramp, 1: all 0xFF, 2: random; pushes expected C in write order.
  task automatic fill(input int mode);
    logic [ACC_W-1:0] s;
    for (int x = 0; x < NN; x++) begin
      mem_a[x] = 8'(mode == 0 ? int'(x / N == x % N) : mode == 1 ? 255 : int'($urandom_range(255)));
      mem_b[x] = 8'(mode == 0 ? x : mode == 1 ? 255 : int'($urandom_range(255)));
    end
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s += ACC_W'(mem_a[i*N+k]) * ACC_W'(mem_b[k*N+j]);
        q_addr.push_back(AW'(i*N + j));
        q_data.push_back(s);
      end
  endtask

  // Cycle numbering: the start edge ends cycle 0; cycle c is sampled 1 time unit after the next edge.
  task automatic run(input string nm, input bit again, input int abort_at);
    int cyc = 0, e, idx;
    bit seen = 0;
    start = 1;
    while (!seen && cyc < T_DONE + 5) begin
      @(posedge clk);
      cyc++;
      #1;
      start = again && cyc >= 20;
      if (abort_at != 0 && cyc == abort_at) begin
        rstn = 0;
        #1;
        chk_zero({nm, "/rst_a"});
        repeat (2) @(posedge clk);
        #1;
        chk_zero({nm, "/rst_b"});
        rstn = 1;
        q_addr.delete();
        q_data.delete();
        return;
      end
      e = cyc - RD_LAT - 1;
      idx = cyc - 1;
      chk({nm, "/ab_re"}, 64'(ab_re), 64'(cyc <= N3));
      chk({nm, "/busy"}, 64'(busy), 64'(cyc <= N3 + RD_LAT + 1));
      chk({nm, "/done"}, 64'(done), 64'(cyc == T_DONE));
      chk({nm, "/c_we"}, 64'(c_we), 64'(e > 0 && e % N == 0 && e <= N3));
      if (ab_re && cyc <= N3) begin
        chk({nm, "/a_addr"}, 64'(a_addr), 64'((idx / NN) * N + idx % N));
        chk({nm, "/b_addr"}, 64'(b_addr), 64'((idx % N) * N + (idx / N) % N));
      end
      if (c_we) begin
        chk({nm, "/sb_nonempty"}, 64'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) begin
          chk({nm, "/c_addr"}, 64'(c_addr), 64'(q_addr.pop_front()));
          chk({nm, "/c_din"}, 64'(c_din), 64'(q_data.pop_front()));
        end
      end
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
      if (cyc == 1) chk({nm, "/cyc_cnt_clr"}, 64'(cycle_cnt), 0);
`endif
      if (done) begin
        seen = 1;
        chk({nm, "/sb_drained"}, 64'(q_addr.size()), 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
        chk({nm, "/cyc_cnt"}, 64'(cycle_cnt), 64'(N3 + RD_LAT + 1));
`endif
      end
    end
    chk({nm, "/done_seen"}, 64'(seen), 1);
    @(posedge clk);
    #1;
    chk({nm, "/idle_ab_re"}, 64'(ab_re), 0);
    chk({nm, "/idle_busy"}, 64'(busy), 0);
    chk({nm, "/idle_done"}, 64'(done), 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    chk({nm, "/cyc_cnt_hold"}, 64'(cycle_cnt), 64'(N3 + RD_LAT + 1));
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1;
    @(posedge clk);
    #1;
    chk_zero("post_reset");
    fill(0); run("ident", 0, 0);
    fill(1); run("ones", 0, 0);
    fill(2); run("again", 1, 0);
    fill(2); run("again2", 0, 0);
    fill(2); run("abort", 0, 30);
    fill(2); run("post_abort", 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
